// File: rtl/psum_drain_pkg.sv
// Shared sizes and FSM encoding for the partial-sum drain block.
package psum_drain_pkg;
    localparam int N_ROW     = 16;
    localparam int N_COL     = 16;
    localparam int ACC_W     = 24;
    localparam int OUT_W     = 8;
    localparam int ROW_W     = N_COL * ACC_W;
    localparam int ARR_W     = N_ROW * ROW_W;
    localparam int ROW_IDX_W = $clog2(N_ROW);
    localparam int SHIFT_W   = 5;

    localparam logic [SHIFT_W-1:0]   MAX_SHIFT = SHIFT_W'(ACC_W - 1);
    localparam logic [ROW_IDX_W-1:0] LAST_ROW  = ROW_IDX_W'(N_ROW - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/psum_requant.sv
// Single-element requantizer: round half-up, arithmetic shift, saturate to int8,
// result sign-extended back into an ACC_W slot.
module psum_requant
    import psum_drain_pkg::*;
(
    input  logic signed [ACC_W-1:0]   i_acc,
    input  logic        [SHIFT_W-1:0] i_shift,
    output logic signed [ACC_W-1:0]   o_q
);

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(-(2**(OUT_W-1)));

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W:0] v);
        logic signed [ACC_W:0] c;
        if (v > SAT_HI)
            c = SAT_HI;
        else if (v < SAT_LO)
            c = SAT_LO;
        else
            c = v;
        return c[OUT_W-1:0];
    endfunction

    logic        [SHIFT_W-1:0] w_s;
    logic signed [ACC_W:0]     w_ext;
    logic signed [ACC_W:0]     w_bias;
    logic signed [ACC_W:0]     w_sum;
    logic signed [ACC_W:0]     w_shr;
    logic signed [OUT_W-1:0]   w_sat;

    // One extra bit of headroom keeps the rounding add from wrapping at +max.
    always_comb begin
        w_s    = (i_shift > MAX_SHIFT) ? MAX_SHIFT : i_shift;
        w_ext  = $signed({i_acc[ACC_W-1], i_acc});
        w_bias = '0;
        if (w_s != '0)
            w_bias = $signed((ACC_W+1)'(1) << (w_s - SHIFT_W'(1)));
        w_sum  = w_ext + w_bias;
        w_shr  = w_sum >>> w_s;
        w_sat  = sat_out(w_shr);
        o_q    = $signed({{(ACC_W-OUT_W){w_sat[OUT_W-1]}}, w_sat});
    end

endmodule

// File: rtl/psum_drain.sv
// Snapshots the MAC partial-sum array on start and streams it out one row per
// valid/ready beat, either raw or requantized to saturated int8.
module psum_drain
    import psum_drain_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ARR_W-1:0]     acc_in,
    input  logic                 quant_en,
    input  logic [SHIFT_W-1:0]   shift,
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ROW_W-1:0]     out_data,
    output logic [ROW_IDX_W-1:0] out_row,
    output logic                 out_last
);

    state_t                 r_state;
    state_t                 w_next;
    logic [ARR_W-1:0]       r_snap;
    logic                   r_quant;
    logic [SHIFT_W-1:0]     r_shift;
    logic [ROW_IDX_W-1:0]   r_row;

    logic                   w_accept;
    logic                   w_fire;
    logic [ROW_W-1:0]       w_row_data;
    logic [ROW_W-1:0]       w_q_row;
    logic [ROW_W-1:0]       w_payload;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_fire   = (r_state == ST_SEND) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_SEND;
            ST_SEND: if (out_ready && (r_row == LAST_ROW)) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        case (r_state)
            ST_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Snapshot and drain mode are frozen at start; later acc_in changes are invisible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_snap  <= '0;
            r_quant <= 1'b0;
            r_shift <= '0;
            r_row   <= '0;
        end else if (w_accept) begin
            r_snap  <= acc_in;
            r_quant <= quant_en;
            r_shift <= shift;
            r_row   <= '0;
        end else if (w_fire) begin
            r_row   <= (r_row == LAST_ROW) ? '0 : r_row + ROW_IDX_W'(1);
        end
    end

    assign w_row_data = r_snap[r_row * ROW_W +: ROW_W];

    for (genvar c = 0; c < N_COL; c++) begin : g_rq
        psum_requant u_rq (
            .i_acc   (w_row_data[c*ACC_W +: ACC_W]),
            .i_shift (r_shift),
            .o_q     (w_q_row[c*ACC_W +: ACC_W])
        );
    end

    assign w_payload = r_quant ? w_q_row : w_row_data;

    // Payload is a pure function of registered state, so it holds under backpressure.
    assign out_data = out_valid ? w_payload : '0;
    assign out_row  = r_row;
    assign out_last = out_valid && (r_row == LAST_ROW);

endmodule

// File: tb/tb_psum_drain.sv
// Directed bench for psum_drain with a queue scoreboard checked by a separate monitor.
module tb_psum_drain;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [6143:0] acc_in;
    logic          quant_en;
    logic [4:0]    shift;
    logic          busy;
    logic          done;
    logic          out_valid;
    logic          out_ready;
    logic [383:0]  out_data;
    logic [3:0]    out_row;
    logic          out_last;

    always #5 clk = ~clk;

    psum_drain dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .acc_in    (acc_in),
        .quant_en  (quant_en),
        .shift     (shift),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    typedef struct {
        logic [3:0]   row;
        logic [383:0] data;
        logic         last;
    } beat_t;

    beat_t       sbq[$];
    beat_t       mon_b;
    int          n_checks = 0;
    int          n_errors = 0;
    int          done_cnt = 0;
    logic [23:0] acc [16][16];

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] qmodel(input logic [23:0] e, input logic [4:0] sh);
        int v;
        int s;
        v = int'($signed(e));
        s = (sh > 5'd23) ? 23 : int'(sh);
        if (s > 0) v = v + (1 << (s - 1));
        v = v >>> s;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 24'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_acc();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                acc_in[r*384 + c*24 +: 24] = acc[r][c];
    endtask

    task automatic push_drain(input logic qm, input logic [4:0] sh);
        beat_t b;
        for (int r = 0; r < 16; r++) begin
            b.row  = 4'(r);
            b.last = (r == 15);
            b.data = '0;
            for (int c = 0; c < 16; c++)
                b.data[c*24 +: 24] = qm ? qmodel(acc[r][c], sh) : acc[r][c];
            sbq.push_back(b);
        end
    endtask

    task automatic start_drain(input logic qm, input logic [4:0] sh);
        quant_en = qm;
        shift    = sh;
        pack_acc();
        push_drain(qm, sh);
        start = 1'b1;
        tick();
        start = 1'b0;
        quant_en = ~qm;
        shift    = ~sh;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk("done_seen", 384'(done), 384'(1));
    endtask

    task automatic finish_drain();
        int n;
        wait_done(n);
        tick();
        chk("done_one_cycle", 384'(done), 384'(0));
        chk("sb_empty", 384'(sbq.size()), 384'(0));
    endtask

    // Monitor: pops and compares on every accepted beat.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_cnt++;
                chk("done_no_valid", 384'(out_valid), 384'(0));
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat_row", 384'(out_row), 384'(16));
                end else begin
                    mon_b = sbq.pop_front();
                    chk("beat_row", 384'(out_row), 384'(mon_b.row));
                    chk("beat_data", out_data, mon_b.data);
                    chk("beat_last", 384'(out_last), 384'(mon_b.last));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [23:0] elem;
        logic [4:0]  sh;
        logic [23:0] exp;
    } qvec_t;

    qvec_t qv[6];
    int    n;
    int    c0;
    logic  any_valid;
    logic [383:0] row5;

    initial begin
        qv[0] = '{24'd384,      5'd4, 24'd24};
        qv[1] = '{24'd24,       5'd4, 24'd2};
        qv[2] = '{24'h7FFFFF,   5'd8, 24'h00007F};
        qv[3] = '{24'hFFFC18,   5'd2, 24'hFFFF80};
        qv[4] = '{24'hFFFFFD,   5'd1, 24'hFFFFFF};
        qv[5] = '{24'hFFFF80,   5'd0, 24'hFFFF80};

        rst = 1'b1; start = 1'b1; quant_en = 1'b0; shift = '0; out_ready = 1'b1;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                acc[r][c] = 24'($urandom);
        pack_acc();

        // Reset behaviour
        tick(); tick(); tick();
        chk("rst_busy", 384'(busy), 384'(0));
        chk("rst_valid", 384'(out_valid), 384'(0));
        chk("rst_done", 384'(done), 384'(0));
        chk("rst_data", out_data, 384'(0));
        start = 1'b0;
        rst = 1'b0;
        tick(); tick(); tick();
        chk("idle_valid", 384'(out_valid), 384'(0));
        chk("idle_data", out_data, 384'(0));
        chk("idle_row", 384'(out_row), 384'(0));
        chk("idle_last", 384'(out_last), 384'(0));

        // Raw drain, ready held high
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                acc[r][c] = 24'(r*16 + c);
        c0 = done_cnt;
        start_drain(1'b0, 5'd0);
        chk("first_valid", 384'(out_valid), 384'(1));
        chk("first_busy", 384'(busy), 384'(1));
        chk("first_row", 384'(out_row), 384'(0));
        tick(); tick(); tick();
        chk("beat3_row", 384'(out_row), 384'(3));
        chk("beat3_slot5", 384'(out_data[5*24 +: 24]), 384'(24'h000035));
        wait_done(n);
        chk("done_latency", 384'(3 + n), 384'(16));
        chk("done_busy_low", 384'(busy), 384'(0));
        tick();
        chk("done_pulse_len", 384'(done), 384'(0));
        chk("raw_done_count", 384'(done_cnt - c0), 384'(1));
        chk("raw_sb_empty", 384'(sbq.size()), 384'(0));

        // Backpressure on row 5
        start_drain(1'b0, 5'd0);
        for (int i = 0; i < 5; i++) tick();
        row5 = '0;
        for (int c = 0; c < 16; c++) row5[c*24 +: 24] = 24'(5*16 + c);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_row", 384'(out_row), 384'(5));
            chk("hold_data", out_data, row5);
            chk("hold_valid", 384'(out_valid), 384'(1));
        end
        out_ready = 1'b1;
        tick();
        chk("after_hold_row", 384'(out_row), 384'(6));
        finish_drain();

        // Requantization vectors
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < 16; r++)
                for (int c = 0; c < 16; c++)
                    acc[r][c] = '0;
            acc[0][k] = qv[k].elem;
            start_drain(1'b1, qv[k].sh);
            chk($sformatf("quant_vec%0d", k), 384'(out_data[k*24 +: 24]), 384'(qv[k].exp));
            finish_drain();
        end

        // Snapshot isolation and start ignored while draining
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                acc[r][c] = 24'($urandom);
        c0 = done_cnt;
        start_drain(1'b0, 5'd0);
        tick();
        acc_in = {192{$urandom}};
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        wait_done(n);
        tick();
        any_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_valid = any_valid | out_valid;
        end
        chk("no_second_drain", 384'(any_valid), 384'(0));
        chk("iso_done_count", 384'(done_cnt - c0), 384'(1));
        chk("iso_sb_empty", 384'(sbq.size()), 384'(0));

        // Reset in the middle of a drain
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                acc[r][c] = 24'($urandom);
        start_drain(1'b0, 5'd0);
        for (int i = 0; i < 7; i++) tick();
        chk("pre_rst_row", 384'(out_row), 384'(7));
        #2;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("async_rst_valid", 384'(out_valid), 384'(0));
        chk("async_rst_busy", 384'(busy), 384'(0));
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 384'(out_valid), 384'(0));
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                acc[r][c] = 24'($urandom);
        start_drain(1'b0, 5'd0);
        chk("post_rst_first_row", 384'(out_row), 384'(0));
        finish_drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
